algo_mrnw_maptbl_mem: RTL and testbench
=======================================

ALGO_MRNW_MAPTBL_MEM -- requirements
Module: algo_mrnw_maptbl_mem

Interface
REQ-001 SHALL have parameter NUMRDPT, default 1, number of independent read ports.
REQ-002 SHALL have parameter NUMWRPT, default 6, number of write ports.
REQ-003 SHALL have parameter WIDTH, default 16, entry width in bits.
REQ-004 SHALL have parameter NUMVROW, default 2048, entry count; BITVROW, default 11, address width.
REQ-005 SHALL have parameter FLOPIN, default 0, where 1 adds one input register stage on all request ports.
REQ-006 SHALL have parameter RDLAT, default 2, range 1..4, cycles from read issue to data.
REQ-007 SHALL have parameter BYPASS, default 0, where 1 makes a same-cycle write visible to a read.
REQ-008 SHALL have parameter INITVAL, default 0, WIDTH-bit value written to every row during init.
REQ-009 SHALL have port clk, input, 1, the sole clock.
REQ-010 SHALL have port rst, input, 1, asynchronous active-low reset.
REQ-011 SHALL have port ready, output, 1, meaning init is complete and requests are accepted.
REQ-012 SHALL have port writeA, input, NUMWRPT, per-port write enable.
REQ-013 SHALL have port addrA, input, NUMWRPT*BITVROW, write addresses, port p at bits [p*BITVROW +: BITVROW].
REQ-014 SHALL have port dinA, input, NUMWRPT*WIDTH, write data, packed the same way.
REQ-015 SHALL have port readB, input, NUMRDPT, per-port read enable.
REQ-016 SHALL have port addrB, input, NUMRDPT*BITVROW, read addresses.
REQ-017 SHALL have port doutB, output, NUMRDPT*WIDTH, read data.
REQ-018 SHALL have port doutB_vld, output, NUMRDPT, per-port read-data valid.
REQ-019 SHALL have port wr_coll, output, 1, flag for a same-address multi-write.

Function
REQ-020 SHALL implement a 2-state FSM, INIT and RUN; reset forces INIT with row counter = 0.
REQ-021 In INIT, SHALL write INITVAL to row counter each cycle and increment the counter; at counter = NUMVROW-1, SHALL go to RUN on the next edge. Init therefore takes exactly NUMVROW cycles after rst rises.
REQ-022 ready SHALL be registered and equal to 1 only in RUN.
REQ-023 While ready = 0, SHALL ignore writeA and readB; no memory update and no doutB_vld.
REQ-024 Issue cycle T SHALL be the edge where a request is sampled: the request cycle if FLOPIN = 0, the request cycle + 1 if FLOPIN = 1. Requests SHALL be gated by ready at the request cycle.
REQ-025 Writes issued at T SHALL update memory at the end of T.
REQ-026 When several enabled write ports share an address at T, the highest-index port SHALL win.
REQ-027 wr_coll SHALL pulse high for one cycle at T+1 for a same-address multi-write at T, otherwise 0.
REQ-028 A read issued at T SHALL return doutB_vld = 1 with data at cycle T+RDLAT; doutB SHALL be 0 whenever the matching vld = 0.
REQ-029 With BYPASS = 0, a read at T SHALL return the contents before T's writes; with BYPASS = 1, it SHALL return the REQ-026 winning write data of T for a matching address.
REQ-030 Writes committed before T SHALL always be visible to a read at T.
REQ-031 Addresses >= NUMVROW SHALL drop writes (still counted for wr_coll) and SHALL return 0 with vld = 1 on reads.
REQ-032 Back-to-back reads on every port every cycle SHALL be sustained, with no stalls.
REQ-033 Read ports SHALL be independent; the same address on multiple read ports SHALL return identical data.

Reset
REQ-034 rst low SHALL asynchronously clear: ready = 0, FSM = INIT, counter = 0, all input/read pipeline valids, doutB_vld = 0, doutB = 0, wr_coll = 0.
REQ-035 Memory array SHALL NOT be reset; the following INIT sequence SHALL overwrite every row.
REQ-036 rst asserted mid-INIT or mid-RUN SHALL abort in-flight reads (no vld issued) and restart init from row 0 after release.

Verification
REQ-037 NUMVROW = 16, INITVAL = 0x00A5: release rst -> ready rises exactly 16 cycles later; reads of rows 0..15 return 0x00A5.
REQ-038 RDLAT = 2, FLOPIN = 0: write row 3 = 0x1234 at T, read row 3 at T+1 -> doutB = 0x1234, vld at T+3.
REQ-039 Ports 1 and 4 both write row 7 (0x1111, 0x4444) at T -> row 7 = 0x4444, wr_coll = 1 at T+1 only.
REQ-040 Row 5 = 0x0001, write 0x0002 and read row 5 same cycle -> BYPASS = 0 returns 0x0001, BYPASS = 1 returns 0x0002.
REQ-041 readB held high with rst pulsed low while reads are in flight -> vld = 0 through re-init; ready deasserted; rows re-read as INITVAL.
REQ-042 Read address 20 with NUMVROW = 16 -> vld = 1 with data 0; write to address 20 leaves all rows unchanged.

Source files
------------

// File: rtl/algo_mrnw_maptbl_mem.sv
// Multi-read / multi-write mapping-table memory with self-initialisation.
// Rows are filled with INITVAL after reset, then requests are served with a fixed read latency.
module algo_mrnw_maptbl_mem #(
  parameter int NUMRDPT = 1,
  parameter int NUMWRPT = 6,
  parameter int WIDTH   = 16,
  parameter int NUMVROW = 2048,
  parameter int BITVROW = 11,
  parameter int FLOPIN  = 0,
  parameter int RDLAT   = 2,
  parameter int BYPASS  = 0,
  parameter logic [WIDTH-1:0] INITVAL = '0
) (
  input  logic                       clk,
  input  logic                       rst,
  output logic                       ready,
  input  logic [NUMWRPT-1:0]         writeA,
  input  logic [NUMWRPT*BITVROW-1:0] addrA,
  input  logic [NUMWRPT*WIDTH-1:0]   dinA,
  input  logic [NUMRDPT-1:0]         readB,
  input  logic [NUMRDPT*BITVROW-1:0] addrB,
  output logic [NUMRDPT*WIDTH-1:0]   doutB,
  output logic [NUMRDPT-1:0]         doutB_vld,
  output logic                       wr_coll
);

  localparam logic [BITVROW-1:0] LASTROW = BITVROW'(NUMVROW - 1);
  localparam logic [BITVROW:0]   ROWLIM  = (BITVROW+1)'(NUMVROW);

  typedef enum logic {INIT, RUN} state_t;

  state_t               state;
  logic [BITVROW-1:0]   rowCnt;
  logic [WIDTH-1:0]     mem [NUMVROW];

  logic [NUMWRPT-1:0]         wrEn_p0;
  logic [NUMWRPT*BITVROW-1:0] wrAddr_p0;
  logic [NUMWRPT*WIDTH-1:0]   wrData_p0;
  logic [NUMRDPT-1:0]         rdEn_p0;
  logic [NUMRDPT*BITVROW-1:0] rdAddr_p0;

  logic [WIDTH-1:0]   rdVal [NUMRDPT];
  logic               collNow;
  logic [NUMRDPT-1:0] rdVldPipe  [RDLAT];
  logic [WIDTH-1:0]   rdDataPipe [RDLAT][NUMRDPT];

  function automatic logic inRange(input logic [BITVROW-1:0] a);
    return ({1'b0, a} < ROWLIM);
  endfunction

  // Init sequencer: one row per cycle, ready asserted together with the move to RUN.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= INIT;
      rowCnt <= '0;
      ready  <= 1'b0;
    end else begin
      case (state)
        INIT: begin
          rowCnt <= rowCnt + BITVROW'(1);
          if (rowCnt == LASTROW) begin
            state <= RUN;
            ready <= 1'b1;
          end
        end
        default: ready <= 1'b1;
      endcase
    end
  end

  // Request stage p0: requests are qualified by ready in the cycle they are presented.
  if (FLOPIN != 0) begin : gFlopIn
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        wrEn_p0 <= '0;
        rdEn_p0 <= '0;
      end else begin
        wrEn_p0 <= writeA & {NUMWRPT{ready}};
        rdEn_p0 <= readB & {NUMRDPT{ready}};
      end
    end
    always_ff @(posedge clk) begin
      wrAddr_p0 <= addrA;
      wrData_p0 <= dinA;
      rdAddr_p0 <= addrB;
    end
  end else begin : gDirectIn
    assign wrEn_p0   = writeA & {NUMWRPT{ready}};
    assign rdEn_p0   = readB & {NUMRDPT{ready}};
    assign wrAddr_p0 = addrA;
    assign wrData_p0 = dinA;
    assign rdAddr_p0 = addrB;
  end

  // Ascending port order makes the highest-index writer the last assignment, so it wins.
  always_ff @(posedge clk) begin
    if (state == INIT) begin
      mem[rowCnt] <= INITVAL;
    end else begin
      for (int p = 0; p < NUMWRPT; p++) begin
        if (wrEn_p0[p] && inRange(wrAddr_p0[p*BITVROW +: BITVROW]))
          mem[wrAddr_p0[p*BITVROW +: BITVROW]] <= wrData_p0[p*WIDTH +: WIDTH];
      end
    end
  end

  always_comb begin
    for (int r = 0; r < NUMRDPT; r++) begin
      rdVal[r] = '0;
      if (inRange(rdAddr_p0[r*BITVROW +: BITVROW])) begin
        rdVal[r] = mem[rdAddr_p0[r*BITVROW +: BITVROW]];
        if (BYPASS != 0) begin
          for (int w = 0; w < NUMWRPT; w++) begin
            if (wrEn_p0[w] && (wrAddr_p0[w*BITVROW +: BITVROW] == rdAddr_p0[r*BITVROW +: BITVROW]))
              rdVal[r] = wrData_p0[w*WIDTH +: WIDTH];
          end
        end
      end
    end
  end

  // Out-of-range addresses still take part in collision detection.
  always_comb begin
    collNow = 1'b0;
    for (int p = 0; p < NUMWRPT; p++) begin
      for (int q = p + 1; q < NUMWRPT; q++) begin
        if (wrEn_p0[p] && wrEn_p0[q] &&
            (wrAddr_p0[p*BITVROW +: BITVROW] == wrAddr_p0[q*BITVROW +: BITVROW]))
          collNow = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) wr_coll <= 1'b0;
    else      wr_coll <= collNow;
  end

  // Read pipeline: stage 0 captures at issue, the last stage drives the outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int s = 0; s < RDLAT; s++) rdVldPipe[s] <= '0;
    end else begin
      rdVldPipe[0] <= rdEn_p0;
      for (int s = 1; s < RDLAT; s++) rdVldPipe[s] <= rdVldPipe[s-1];
    end
  end

  always_ff @(posedge clk) begin
    for (int r = 0; r < NUMRDPT; r++) begin
      rdDataPipe[0][r] <= rdVal[r];
      for (int s = 1; s < RDLAT; s++) rdDataPipe[s][r] <= rdDataPipe[s-1][r];
    end
  end

  assign doutB_vld = rdVldPipe[RDLAT-1];

  for (genvar r = 0; r < NUMRDPT; r++) begin : gOut
    assign doutB[r*WIDTH +: WIDTH] = rdVldPipe[RDLAT-1][r] ? rdDataPipe[RDLAT-1][r] : '0;
  end

endmodule

// File: tb/tb_algo_mrnw_maptbl_mem.sv
// Scoreboard bench: two instances (BYPASS 0 and 1) share stimulus; a memory-array model predicts reads.
module tb_algo_mrnw_maptbl_mem;
  localparam int NR  = 2;
  localparam int NW  = 6;
  localparam int W   = 16;
  localparam int NV  = 16;
  localparam int BV  = 5;
  localparam int RL  = 2;
  localparam int FI  = 0;
  localparam int LAT = RL + FI;
  localparam logic [W-1:0] IV = 16'h00A5;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [NW-1:0]    writeA;
  logic [NW*BV-1:0] addrA;
  logic [NW*W-1:0]  dinA;
  logic [NR-1:0]    readB;
  logic [NR*BV-1:0] addrB;
  logic             ready0, ready1, coll0, coll1;
  logic [NR*W-1:0]  dout0, dout1;
  logic [NR-1:0]    vld0, vld1;

  algo_mrnw_maptbl_mem #(.NUMRDPT(NR), .NUMWRPT(NW), .WIDTH(W), .NUMVROW(NV), .BITVROW(BV),
    .FLOPIN(FI), .RDLAT(RL), .BYPASS(0), .INITVAL(IV)) dut0 (
    .clk(clk), .rst(rst), .ready(ready0), .writeA(writeA), .addrA(addrA), .dinA(dinA),
    .readB(readB), .addrB(addrB), .doutB(dout0), .doutB_vld(vld0), .wr_coll(coll0));

  algo_mrnw_maptbl_mem #(.NUMRDPT(NR), .NUMWRPT(NW), .WIDTH(W), .NUMVROW(NV), .BITVROW(BV),
    .FLOPIN(FI), .RDLAT(RL), .BYPASS(1), .INITVAL(IV)) dut1 (
    .clk(clk), .rst(rst), .ready(ready1), .writeA(writeA), .addrA(addrA), .dinA(dinA),
    .readB(readB), .addrB(addrB), .doutB(dout1), .doutB_vld(vld1), .wr_coll(coll1));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int           cyc;
    int           port;
    logic [W-1:0] d0;
    logic [W-1:0] d1;
  } exp_t;

  exp_t         sb[$];
  logic [W-1:0] mdl [NV];
  bit           mReady = 1'b0;
  logic         expColl [8];
  int           checks = 0;
  int           failures = 0;

  logic         wEn [NW];
  logic [BV-1:0] wAd [NW];
  logic [W-1:0] wDt [NW];
  logic         rEn [NR];
  logic [BV-1:0] rAd [NR];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s cyc=%0d actual=0x%0h required=0x%0h", nm, cyc, act, req);
    end
  endtask

  task automatic clearReq();
    for (int i = 0; i < NW; i++) begin wEn[i] = 1'b0; wAd[i] = '0; wDt[i] = '0; end
    for (int r = 0; r < NR; r++) begin rEn[r] = 1'b0; rAd[r] = '0; end
  endtask

  // Drive the DUT inputs and, when the table is accepting, record what it must answer.
  task automatic apply();
    exp_t e;
    logic coll;
    for (int i = 0; i < NW; i++) begin
      writeA[i] = wEn[i];
      addrA[i*BV +: BV] = wAd[i];
      dinA[i*W +: W] = wDt[i];
    end
    for (int r = 0; r < NR; r++) begin
      readB[r] = rEn[r];
      addrB[r*BV +: BV] = rAd[r];
    end
    if (mReady) begin
      for (int r = 0; r < NR; r++) begin
        if (rEn[r]) begin
          e.cyc = cyc + LAT;
          e.port = r;
          e.d0 = '0;
          e.d1 = '0;
          if (int'(rAd[r]) < NV) begin
            e.d0 = mdl[rAd[r]];
            e.d1 = e.d0;
            for (int i = 0; i < NW; i++)
              if (wEn[i] && wAd[i] == rAd[r]) e.d1 = wDt[i];
          end
          sb.push_back(e);
        end
      end
      coll = 1'b0;
      for (int i = 0; i < NW; i++)
        for (int j = 0; j < NW; j++)
          if (i != j && wEn[i] && wEn[j] && wAd[i] == wAd[j]) coll = 1'b1;
      expColl[(cyc + 1 + FI) % 8] = coll;
      for (int i = 0; i < NW; i++)
        if (wEn[i] && int'(wAd[i]) < NV) mdl[wAd[i]] = wDt[i];
    end
  endtask

  task automatic cycle();
    @(negedge clk);
    apply();
    clearReq();
  endtask

  task automatic initSeq();
    int readyAt;
    readyAt = 0;
    @(negedge clk);
    rst = 1'b1;
    for (int k = 1; k <= 40 && readyAt == 0; k++) begin
      @(posedge clk);
      #1;
      if (ready0) readyAt = k;
      else begin
        @(negedge clk);
        for (int i = 0; i < NW; i++) begin
          wEn[i] = ($urandom_range(0, 1) == 1);
          wAd[i] = BV'($urandom_range(0, NV - 1));
          wDt[i] = W'($urandom);
        end
        for (int r = 0; r < NR; r++) begin rEn[r] = 1'b1; rAd[r] = BV'($urandom_range(0, NV - 1)); end
        apply();
      end
    end
    chk("init_len", 32'(readyAt), 32'd16);
    chk("ready_byp", 32'(ready1), 32'd1);
    for (int i = 0; i < NV; i++) mdl[i] = IV;
    mReady = 1'b1;
  endtask

  task automatic readAll();
    for (int i = 0; i < NV; i += 2) begin
      rEn[0] = 1'b1; rAd[0] = BV'(i);
      rEn[1] = 1'b1; rAd[1] = BV'(i + 1);
      cycle();
    end
  endtask

  task automatic resetAssert();
    @(negedge clk);
    rst = 1'b0;
    mReady = 1'b0;
    sb.delete();
    for (int i = 0; i < 8; i++) expColl[i] = 1'b0;
    for (int r = 0; r < NR; r++) begin rEn[r] = 1'b1; rAd[r] = BV'(r + 3); end
    apply();
    #1;
    chk("rst_ready", 32'({ready1, ready0}), 32'd0);
    chk("rst_vld", 32'({vld1, vld0}), 32'd0);
    chk("rst_dout", {dout1, dout0}, 32'd0);
    chk("rst_coll", 32'({coll1, coll0}), 32'd0);
  endtask

  // Monitor: every cycle, each port must show exactly what the scoreboard predicts.
  initial begin : monitor
    bit           ev [NR];
    logic [W-1:0] e0 [NR];
    logic [W-1:0] e1 [NR];
    exp_t         e;
    forever begin
      @(posedge clk);
      #1;
      for (int r = 0; r < NR; r++) begin ev[r] = 1'b0; e0[r] = '0; e1[r] = '0; end
      while (sb.size() > 0 && sb[0].cyc <= cyc) begin
        e = sb.pop_front();
        if (e.cyc < cyc) chk("stale_entry", 32'(e.cyc), 32'(cyc));
        else begin
          ev[e.port] = 1'b1;
          e0[e.port] = e.d0;
          e1[e.port] = e.d1;
        end
      end
      for (int r = 0; r < NR; r++) begin
        chk($sformatf("vld_nobyp_p%0d", r), 32'(vld0[r]), 32'(ev[r]));
        chk($sformatf("vld_byp_p%0d", r), 32'(vld1[r]), 32'(ev[r]));
        chk($sformatf("dout_nobyp_p%0d", r), 32'(dout0[r*W +: W]), 32'(e0[r]));
        chk($sformatf("dout_byp_p%0d", r), 32'(dout1[r*W +: W]), 32'(e1[r]));
      end
      chk("wr_coll_nobyp", 32'(coll0), 32'(expColl[cyc % 8]));
      chk("wr_coll_byp", 32'(coll1), 32'(expColl[cyc % 8]));
      expColl[cyc % 8] = 1'b0;
    end
  end

  initial begin : stimulus
    for (int i = 0; i < 8; i++) expColl[i] = 1'b0;
    for (int i = 0; i < NV; i++) mdl[i] = '0;
    clearReq();
    apply();
    repeat (3) @(negedge clk);
    #1;
    chk("rst_ready", 32'({ready1, ready0}), 32'd0);
    chk("rst_vld", 32'({vld1, vld0}), 32'd0);
    chk("rst_dout", {dout1, dout0}, 32'd0);
    chk("rst_coll", 32'({coll1, coll0}), 32'd0);

    initSeq();
    readAll();

    wEn[0] = 1'b1; wAd[0] = 5'd3; wDt[0] = 16'h1234; cycle();
    rEn[0] = 1'b1; rAd[0] = 5'd3; cycle();

    wEn[1] = 1'b1; wAd[1] = 5'd7; wDt[1] = 16'h1111;
    wEn[4] = 1'b1; wAd[4] = 5'd7; wDt[4] = 16'h4444; cycle();
    cycle();
    rEn[0] = 1'b1; rAd[0] = 5'd7; rEn[1] = 1'b1; rAd[1] = 5'd7; cycle();

    wEn[2] = 1'b1; wAd[2] = 5'd5; wDt[2] = 16'h0001; cycle();
    wEn[3] = 1'b1; wAd[3] = 5'd5; wDt[3] = 16'h0002; rEn[0] = 1'b1; rAd[0] = 5'd5; cycle();
    rEn[1] = 1'b1; rAd[1] = 5'd5; cycle();

    rEn[0] = 1'b1; rAd[0] = 5'd20; wEn[5] = 1'b1; wAd[5] = 5'd20; wDt[5] = 16'hDEAD; cycle();
    wEn[0] = 1'b1; wAd[0] = 5'd20; wDt[0] = 16'hBEEF;
    wEn[2] = 1'b1; wAd[2] = 5'd20; wDt[2] = 16'hCAFE; cycle();
    readAll();

    repeat (300) begin
      for (int i = 0; i < NW; i++) begin
        wEn[i] = ($urandom_range(0, 3) == 0);
        wAd[i] = BV'($urandom_range(0, 19));
        wDt[i] = W'($urandom);
      end
      for (int r = 0; r < NR; r++) begin
        rEn[r] = ($urandom_range(0, 1) == 1);
        rAd[r] = BV'($urandom_range(0, 19));
      end
      cycle();
    end
    readAll();

    for (int r = 0; r < NR; r++) begin rEn[r] = 1'b1; rAd[r] = BV'(r + 3); end
    apply();
    @(negedge clk);
    for (int r = 0; r < NR; r++) begin rEn[r] = 1'b1; rAd[r] = BV'(r + 5); end
    apply();
    resetAssert();
    repeat (2) @(negedge clk);
    initSeq();
    clearReq();
    readAll();

    repeat (6) cycle();
    chk("drain", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
